// File: rtl/instr_enc_pkg.sv
// Shared encoder definitions: mnemonic codes, ARM-style cmd/cond/op constants,
// and the registered instruction-field payload used between loader and packer.
package instr_enc_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned CNT_W  = 7;
    localparam int unsigned IMM_W  = 24;
    localparam int unsigned REG_W  = 4;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_ORR  = 4'd3,
        OP_CMP  = 4'd4,
        OP_LDR  = 4'd5,
        OP_LDRB = 4'd6,
        OP_STR  = 4'd7,
        OP_STRB = 4'd8,
        OP_B    = 4'd9
    } enc_op_t;

    // Data-processing cmd field values
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Condition "always"
    localparam logic [3:0] COND_AL = 4'b1110;

    // Op field [27:26]
    localparam logic [1:0] OPF_DP  = 2'b00;
    localparam logic [1:0] OPF_MEM = 2'b01;
    localparam logic [1:0] OPF_BR  = 2'b10;

    // Opcode kept as raw bits so unimplemented codes can be carried and rejected
    typedef struct packed {
        logic [3:0]       opc;
        logic             use_imm;
        logic             set_flags;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rn;
        logic [REG_W-1:0] rm;
        logic [IMM_W-1:0] imm;
    } instr_fields_t;

endpackage

// File: rtl/instr_field_pack.sv
// Combinational instruction packer.
// Ports: fields_i  - registered instruction fields
//        word_o    - encoded 32-bit machine word
//        illegal_o - instruction cannot be encoded (unimplemented opc or oversize immediate)
module instr_field_pack
    import instr_enc_pkg::*;
(
    input  instr_fields_t     fields_i,
    output logic [DATA_W-1:0] word_o,
    output logic              illegal_o
);

    logic [3:0]       cmd;
    logic             s_bit;
    logic [REG_W-1:0] rd_eff;
    logic [11:0]      src2;
    logic             b_bit;
    logic             l_bit;

    // Data-processing field derivation; CMP always sets flags and has no destination
    always_comb begin
        cmd    = CMD_AND;
        s_bit  = fields_i.set_flags;
        rd_eff = fields_i.rd;
        case (fields_i.opc)
            OP_ADD:  cmd = CMD_ADD;
            OP_SUB:  cmd = CMD_SUB;
            OP_AND:  cmd = CMD_AND;
            OP_ORR:  cmd = CMD_ORR;
            OP_CMP: begin
                cmd    = CMD_CMP;
                s_bit  = 1'b1;
                rd_eff = '0;
            end
            default: cmd = CMD_AND;
        endcase
        src2 = fields_i.use_imm ? {4'b0000, fields_i.imm[7:0]} : {8'h00, fields_i.rm};
    end

    assign b_bit = (fields_i.opc == OP_LDRB) || (fields_i.opc == OP_STRB);
    assign l_bit = (fields_i.opc == OP_LDR)  || (fields_i.opc == OP_LDRB);

    // Word assembly per instruction class
    always_comb begin
        word_o    = '0;
        illegal_o = 1'b0;
        case (fields_i.opc)
            OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_CMP: begin
                word_o    = {COND_AL, OPF_DP, fields_i.use_imm, cmd, s_bit,
                             fields_i.rn, rd_eff, src2};
                illegal_o = fields_i.use_imm && (fields_i.imm[23:8] != 16'h0000);
            end
            OP_LDR, OP_LDRB, OP_STR, OP_STRB: begin
                word_o    = {COND_AL, OPF_MEM, 1'b0, 1'b1, 1'b1, b_bit, 1'b0, l_bit,
                             fields_i.rn, fields_i.rd, fields_i.imm[11:0]};
                illegal_o = (fields_i.imm[23:12] != 12'h000);
            end
            OP_B: begin
                word_o = {COND_AL, OPF_BR, 2'b10, fields_i.imm};
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts instruction fields, encodes them and writes the
// machine words to consecutive instruction-memory addresses.
// Ports: clk/reset (sync, active-high); start opens a new load;
//        in_valid/in_ready/in_last + opc/use_imm/set_flags/rd/rn/rm/imm field input;
//        mem_we/mem_addr/mem_wdata memory write port; count/done/err status.
module instr_encoder_loader
    import instr_enc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [3:0]        opc,
    input  logic              use_imm,
    input  logic              set_flags,
    input  logic [REG_W-1:0]  rd,
    input  logic [REG_W-1:0]  rn,
    input  logic [REG_W-1:0]  rm,
    input  logic [IMM_W-1:0]  imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [CNT_W-1:0]  count,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE, S_ACCEPT, S_ENCODE, S_WRITE, S_DONE, S_FULL
    } state_t;

    state_t            state_q, state_d;
    instr_fields_t     fields_q, fields_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] pack_word;
    logic              pack_illegal;

    instr_field_pack u_pack (
        .fields_i  (fields_q),
        .word_o    (pack_word),
        .illegal_o (pack_illegal)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        fields_d = fields_q;
        last_d   = last_q;
        addr_d   = addr_q;
        count_d  = count_q;
        wdata_d  = wdata_q;
        err_d    = err_q;

        if (start) begin
            // start from any state drops whatever is in flight
            state_d = S_ACCEPT;
            addr_d  = '0;
            count_d = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: ;
                S_ACCEPT: begin
                    if (in_valid && ready_q) begin
                        fields_d = '{opc: opc, use_imm: use_imm, set_flags: set_flags,
                                     rd: rd, rn: rn, rm: rm, imm: imm};
                        last_d   = in_last;
                        state_d  = S_ENCODE;
                    end
                end
                S_ENCODE: begin
                    if (pack_illegal) begin
                        err_d   = 1'b1;
                        state_d = last_q ? S_DONE : S_ACCEPT;
                    end else begin
                        wdata_d = pack_word;
                        state_d = S_WRITE;
                    end
                end
                S_WRITE: begin
                    addr_d  = addr_q + ADDR_W'(1);
                    count_d = count_q + CNT_W'(1);
                    if (last_q) begin
                        state_d = S_DONE;
                    end else if (addr_q == ADDR_W'(63)) begin
                        state_d = S_FULL;
                    end else begin
                        state_d = S_ACCEPT;
                    end
                end
                S_DONE, S_FULL: ;
                default: state_d = S_IDLE;
            endcase
        end

        // Status outputs are decoded from the next state so they register with it
        ready_d = (state_d == S_ACCEPT);
        we_d    = (state_d == S_WRITE);
        done_d  = (state_d == S_DONE) || (state_d == S_FULL);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            fields_q <= '0;
            last_q   <= 1'b0;
            addr_q   <= '0;
            count_q  <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            fields_q <= fields_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            we_q     <= we_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    assign in_ready  = ready_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign count     = count_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: doc/instr_encoder_loader.md
INSTR_ENCODER_LOADER -- requirements
Module: instr_encoder_loader

Interface
REQ-001 The block SHALL have one clock and use a synchronous, active-high reset.
REQ-002 Port list SHALL be as follows (clock and reset first):
  clk  input  1  system clock
  reset  input  1  synchronous, active-high reset
  start  input  1  one-cycle pulse; clears address/count/done/err and opens a new program load
  in_valid  input  1  instruction fields valid
  in_ready  output  1  block can accept fields this cycle
  in_last  input  1  final instruction of the program; qualified by in_valid
  opc  input  4  mnemonic code (enc_op_t): ADD, SUB, AND, ORR, CMP, LDR, LDRB, STR, STRB, B
  use_imm  input  1  data-processing source 2 is immediate (1) or Rm (0)
  set_flags  input  1  S bit for ADD/SUB/AND/ORR
  rd, rn, rm  input  4 each  register fields
  imm  input  24  immediate / offset / branch word offset (two's complement for B)
  mem_we  output  1  instruction-memory write strobe
  mem_addr  output  6  instruction-memory word address
  mem_wdata  output  32  encoded machine word
  count  output  7  instructions written since start
  done  output  1  program load complete
  err  output  1  sticky: at least one instruction rejected

Function
REQ-003 FSM states SHALL be IDLE, ACCEPT, ENCODE, WRITE, DONE, FULL.
REQ-004 In IDLE, in_ready SHALL be 0; start SHALL go to ACCEPT.
REQ-005 In ACCEPT, in_ready SHALL be 1; the in_valid&in_ready transfer SHALL register all fields and go to ENCODE.
REQ-006 ENCODE SHALL last one cycle, register mem_wdata, and go to WRITE, or to ACCEPT with err set if the instruction is illegal.
REQ-007 WRITE SHALL assert mem_we for exactly one cycle at the current mem_addr, then increment mem_addr and count.
REQ-008 Latency: fields accepted in cycle N SHALL produce mem_we in cycle N+2; throughput SHALL be one instruction per 3 cycles.
REQ-009 The cond field [31:28] SHALL be 4'b1110 for every instruction.
REQ-010 Data-processing encoding: op=00, funct={use_imm, cmd, S}, with cmd ADD=0100, SUB=0010, AND=0000, ORR=1100, CMP=1010; CMP SHALL force S=1 and Rd=0; src2 SHALL be imm[7:0] zero-extended to 12 bits or {8'b0, rm}.
REQ-011 Memory encoding: op=01, funct={0,1,1,B,0,L}, with B=1 for LDRB/STRB and L=1 for LDR/LDRB; [11:0]=imm[11:0]; Rd is the data register.
REQ-012 Branch encoding: op=10, bits[25:24]=10, [23:0]=imm.
REQ-013 Illegal cases: opc is unimplemented; the data-processing immediate has imm[23:8]!=0; the memory offset has imm[23:12]!=0. An illegal instruction SHALL be dropped, mem_we SHALL stay 0, address and count SHALL not advance, and err SHALL set.
REQ-014 After WRITE, the FSM SHALL go to DONE if the accepted instruction had in_last=1; otherwise it SHALL go to FULL if mem_addr wrapped to 0 (64 writes); otherwise it SHALL go to ACCEPT.
REQ-015 An illegal in_last instruction SHALL still go to DONE.
REQ-016 DONE SHALL hold done=1 and in_ready=0 until start.
REQ-017 FULL SHALL hold in_ready=0 and done=1, with count=64 and mem_addr=0; further in_valid SHALL be ignored.
REQ-018 start in any state other than IDLE/DONE/FULL SHALL abort the current instruction (no write) and restart in ACCEPT with cleared counters.

Reset
REQ-019 Reset SHALL put the FSM in IDLE and set in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, count=0, done=0, err=0.
REQ-020 Reset SHALL take priority over start and over any in-flight instruction.

Structure
REQ-021 enc_op_t, the cmd constants, the cond constant AL, and the op-field constants SHALL reside in the shared package instr_enc_pkg.
REQ-022 Field packing SHALL be a combinational sub-module instr_field_pack (fields in, word + illegal out); the FSM SHALL be in the top module.

Verification
REQ-023 ADD rd=1, rn=2, imm=5, use_imm=1 -> mem_we at N+2, addr 0, word 0xE2821005.
REQ-024 SUB S=1 rd=3, rn=4, rm=5; then CMP rn=0, imm=10 -> words 0xE0543005 and 0xE350000A, count=2.
REQ-025 LDR rd=1, rn=2, imm=4; STRB same fields; B imm=0xFFFFFE with in_last -> 0xE5921004, 0xE5C21004, 0xEAFFFFFE, then done=1.
REQ-026 ADD imm=0x100 -> no mem_we, err=1, address unchanged; the next legal instruction is written at the same address.
REQ-027 64 back-to-back legal instructions -> the 64th write is at addr 63; then FULL, in_ready=0, count=64; a 65th in_valid produces no write.
REQ-028 Reset asserted during ENCODE -> no mem_we, and all outputs match the reset values next cycle.
